// File: rtl/bw10g_pkg.sv
// Shared types and constants for the 10G bandwidth scheduler datapath.
package bw10g_pkg;

    localparam logic [7:0] GRANT_SOP     = 8'h80;
    localparam int         WIRE_OVERHEAD = 20;
    localparam int         MIN_FRAME     = 64;

    typedef struct packed {
        logic [15:0] id;
        logic [13:0] len;
    } req_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SOP,
        ST_BODY
    } state_t;

endpackage

// File: rtl/bw10g_req_fifo.sv
// Small synchronous request FIFO with full/empty flags; a pop frees a slot for a same-cycle push.
module bw10g_req_fifo
    import bw10g_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic push,
    input  req_t push_data,
    input  logic pop,
    output req_t pop_data,
    output logic full,
    output logic empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    req_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/stream_frame_builder_10g.sv
// Turns scheduler frame-start grants into synthetic 64-bit Ethernet beat streams.
// Define FRAME_BUILDER_SEQ_EN to carry per-stream sequence numbers in header bytes 2-5.
module stream_frame_builder_10g
    import bw10g_pkg::*;
#(
    parameter int NUM_STREAMS = 64,
    parameter int FIFO_DEPTH  = 4,
    parameter int MAX_LEN     = 9216
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        tx_enable,
    input  logic [15:0] sched_id,
    input  logic [7:0]  sched_valid,
    output logic [5:0]  len_sel,
    input  logic [15:0] len_in,
    output logic [63:0] tx_data,
    output logic [7:0]  tx_keep,
    output logic        tx_sop,
    output logic        tx_eop,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [15:0] tx_stream_id,
    output logic [15:0] drop_count
);

    state_t      state;
    state_t      next_state;
    logic        grant;
    logic        pop;
    logic        fifo_full;
    logic        fifo_empty;
    req_t        push_req;
    req_t        head_req;
    logic [13:0] frame_len;
    logic [15:0] cur_id;
    logic [13:0] cur_len;
    logic [10:0] beat_idx;
    logic [10:0] last_idx;
    logic        is_last;
    logic [31:0] cur_seq;

    assign len_sel = 6'(sched_id - 16'd1);
    assign grant   = tx_enable && (sched_valid == GRANT_SOP) &&
                     (sched_id != 16'd0) && (sched_id <= 16'(NUM_STREAMS));

    // Payload length excludes preamble and IFG, clamped to a legal frame size.
    always_comb begin
        frame_len = 14'(MIN_FRAME);
        if (len_in >= 16'(MIN_FRAME + WIRE_OVERHEAD)) begin
            if ((len_in - 16'(WIRE_OVERHEAD)) > 16'(MAX_LEN)) begin
                frame_len = 14'(MAX_LEN);
            end else begin
                frame_len = 14'(len_in - 16'(WIRE_OVERHEAD));
            end
        end
    end

    assign push_req = '{id: sched_id, len: frame_len};

    bw10g_req_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_req_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (grant),
        .push_data (push_req),
        .pop       (pop),
        .pop_data  (head_req),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign tx_valid = (state != ST_IDLE);
    assign last_idx = 11'((cur_len - 14'd1) >> 3);
    assign is_last  = (beat_idx == last_idx);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The next request is popped on the final handshake so frames run back-to-back.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    next_state = ST_SOP;
                end
            end
            ST_SOP, ST_BODY: begin
                if (tx_ready) begin
                    if (is_last) begin
                        if (!fifo_empty) begin
                            pop        = 1'b1;
                            next_state = ST_SOP;
                        end else begin
                            next_state = ST_IDLE;
                        end
                    end else begin
                        next_state = ST_BODY;
                    end
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cur_id     <= '0;
            cur_len    <= '0;
            beat_idx   <= '0;
            drop_count <= '0;
        end else begin
            if (pop) begin
                cur_id   <= head_req.id;
                cur_len  <= head_req.len;
                beat_idx <= '0;
            end else if (tx_valid && tx_ready) begin
                beat_idx <= beat_idx + 1'b1;
            end
            if (grant && fifo_full && !pop && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

`ifdef FRAME_BUILDER_SEQ_EN
    localparam int IW = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1;

    logic [31:0]   seq_mem [NUM_STREAMS];
    logic [IW-1:0] cur_idx;

    assign cur_idx = IW'(cur_id - 16'd1);
    assign cur_seq = seq_mem[cur_idx];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_STREAMS; i++) begin
                seq_mem[i] <= '0;
            end
        end else if (tx_sop && tx_ready) begin
            seq_mem[cur_idx] <= seq_mem[cur_idx] + 32'd1;
        end
    end
`else
    assign cur_seq = '0;
`endif

    // Header fields are big-endian; payload byte k carries k[7:0].
    always_comb begin
        tx_data      = '0;
        tx_keep      = '0;
        tx_sop       = 1'b0;
        tx_eop       = 1'b0;
        tx_stream_id = '0;
        if (tx_valid) begin
            tx_stream_id = cur_id;
            tx_sop       = (state == ST_SOP);
            tx_eop       = is_last;
            tx_keep      = 8'hFF;
            if (is_last && (cur_len[2:0] != 3'd0)) begin
                tx_keep = 8'((9'd1 << cur_len[2:0]) - 9'd1);
            end
            if (state == ST_SOP) begin
                tx_data = {cur_len[7:0], 2'b00, cur_len[13:8],
                           cur_seq[7:0], cur_seq[15:8], cur_seq[23:16], cur_seq[31:24],
                           cur_id[7:0], cur_id[15:8]};
            end else begin
                for (int j = 0; j < 8; j++) begin
                    tx_data[8*j +: 8] = {beat_idx[4:0], 3'(j)};
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_frame_builder_10g.sv
// Directed bench for stream_frame_builder_10g: vector table of single frames plus multi-cycle corner sequences.
module tb_stream_frame_builder_10g;

    logic        clock;
    logic        reset_n;
    logic        tx_enable;
    logic [15:0] sched_id;
    logic [7:0]  sched_valid;
    logic [5:0]  len_sel;
    logic [15:0] len_in;
    logic [63:0] tx_data;
    logic [7:0]  tx_keep;
    logic        tx_sop;
    logic        tx_eop;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] tx_stream_id;
    logic [15:0] drop_count;

    int n_checks;
    int n_failures;
    logic [31:0] seq_model [0:64];

    typedef struct {
        logic [15:0] id;
        logic [15:0] len_in;
        int          exp_len;
        logic [7:0]  exp_last_keep;
        logic [7:0]  exp_last_byte;
    } vec_t;

    vec_t vecs [8];

    stream_frame_builder_10g dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .tx_enable    (tx_enable),
        .sched_id     (sched_id),
        .sched_valid  (sched_valid),
        .len_sel      (len_sel),
        .len_in       (len_in),
        .tx_data      (tx_data),
        .tx_keep      (tx_keep),
        .tx_sop       (tx_sop),
        .tx_eop       (tx_eop),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_stream_id (tx_stream_id),
        .drop_count   (drop_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_failures++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    // Drive one cycle of scheduler output, then return the bus to idle.
    task automatic apply_stimulus(input logic [15:0] id, input logic [7:0] code,
                                  input logic [15:0] len, output logic [5:0] sel_seen);
        sched_id    = id;
        sched_valid = code;
        len_in      = len;
        #1;
        sel_seen = len_sel;
        step();
        sched_id    = 16'd0;
        sched_valid = 8'd0;
        len_in      = 16'd0;
    endtask

    function automatic logic [31:0] exp_seq(input int id);
`ifdef FRAME_BUILDER_SEQ_EN
        return seq_model[id];
`else
        return (id < 0) ? 32'd1 : 32'd0;
`endif
    endfunction

    function automatic logic [63:0] exp_beat(input logic [15:0] id, input int len,
                                             input logic [31:0] seq, input int b);
        logic [63:0] d;
        logic [15:0] l16;
        l16 = 16'(len);
        d   = '0;
        if (b == 0) begin
            d = {l16[7:0], l16[15:8], seq[7:0], seq[15:8], seq[23:16], seq[31:24], id[7:0], id[15:8]};
        end else begin
            for (int j = 0; j < 8; j++) begin
                d[8*j +: 8] = 8'((8*b + j) % 256);
            end
        end
        return d;
    endfunction

    function automatic logic [7:0] exp_keep(input int len, input int b);
        int nb;
        int r;
        nb = (len + 7) / 8;
        r  = len % 8;
        if (b == nb - 1 && r != 0) return 8'((1 << r) - 1);
        return 8'hFF;
    endfunction

    // Receive one whole frame starting at its SOP; tx_ready is assumed high.
    task automatic collect_frame(input string tag, input logic [15:0] id, input int len,
                                 input logic [31:0] seq, output int waited,
                                 output logic [7:0] last_keep, output logic [7:0] last_byte);
        int          nb;
        int          bad;
        logic [63:0] m;
        logic [7:0]  k;
        waited    = 0;
        last_keep = 8'h00;
        last_byte = 8'h00;
        while (tx_valid !== 1'b1 && waited < 100) begin
            step();
            waited++;
        end
        check_output({tag, " sop_seen"}, {63'd0, tx_valid & tx_sop}, 64'd1);
        if (tx_valid !== 1'b1) return;
        check_output({tag, " header"}, tx_data, exp_beat(id, len, seq, 0));
        nb  = (len + 7) / 8;
        bad = 0;
        for (int b = 0; b < nb; b++) begin
            k = exp_keep(len, b);
            for (int j = 0; j < 8; j++) m[8*j +: 8] = {8{k[j]}};
            if (tx_valid !== 1'b1 || tx_sop !== (b == 0) || tx_eop !== (b == nb - 1) ||
                tx_keep !== k || (tx_data & m) !== (exp_beat(id, len, seq, b) & m) ||
                tx_stream_id !== id) begin
                bad++;
            end
            if (b == nb - 1) begin
                last_keep = tx_keep;
                last_byte = tx_data[8*((len - 1) % 8) +: 8];
            end
            step();
        end
        check_output({tag, " bad_beats"}, 64'(bad), 64'd0);
    endtask

    initial begin
        logic [5:0]  sel;
        int          waited;
        logic [7:0]  lk;
        logic [7:0]  lb;
        logic [90:0] snap;
        int          bad;
        int          sops;
        int          eops;
        int          lanes_checked;

        n_checks    = 0;
        n_failures  = 0;
        reset_n     = 1'b0;
        tx_enable   = 1'b0;
        sched_id    = 16'd0;
        sched_valid = 8'd0;
        len_in      = 16'd0;
        tx_ready    = 1'b1;
        for (int i = 0; i <= 64; i++) seq_model[i] = 32'd0;

        vecs[0] = '{16'd3,  16'd84,    64,   8'hFF, 8'h3F};
        vecs[1] = '{16'd1,  16'd85,    65,   8'h01, 8'h40};
        vecs[2] = '{16'd9,  16'd10,    64,   8'hFF, 8'h3F};
        vecs[3] = '{16'd12, 16'd83,    64,   8'hFF, 8'h3F};
        vecs[4] = '{16'd2,  16'd103,   83,   8'h07, 8'h52};
        vecs[5] = '{16'd40, 16'd1000,  980,  8'h0F, 8'hD3};
        vecs[6] = '{16'd64, 16'd20000, 9216, 8'hFF, 8'hFF};
        vecs[7] = '{16'd13, 16'd9237,  9216, 8'hFF, 8'hFF};

        #12;
        check_output("reset_data", tx_data, 64'd0);
        check_output("reset_ctrl", {21'd0, tx_valid, tx_sop, tx_eop, tx_keep, tx_stream_id, drop_count}, 64'd0);
        reset_n = 1'b1;
        step();
        tx_enable = 1'b1;

        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vecs[i].id, 8'h80, vecs[i].len_in, sel);
            check_output($sformatf("vec%0d len_sel", i), 64'(sel), 64'(6'(vecs[i].id - 16'd1)));
            collect_frame($sformatf("vec%0d", i), vecs[i].id, vecs[i].exp_len,
                          exp_seq(vecs[i].id), waited, lk, lb);
            seq_model[vecs[i].id]++;
            check_output($sformatf("vec%0d latency", i), 64'(waited), 64'd1);
            check_output($sformatf("vec%0d last_keep", i), 64'(lk), 64'(vecs[i].exp_last_keep));
            check_output($sformatf("vec%0d last_byte", i), 64'(lb), 64'(vecs[i].exp_last_byte));
        end

        // Two grants on consecutive cycles for the same stream: no bubble, seq advances.
        apply_stimulus(16'd5, 8'h80, 16'd84, sel);
        apply_stimulus(16'd5, 8'h80, 16'd84, sel);
        collect_frame("b2b_first", 16'd5, 64, exp_seq(5), waited, lk, lb);
        seq_model[5]++;
        collect_frame("b2b_second", 16'd5, 64, exp_seq(5), waited, lk, lb);
        seq_model[5]++;
        check_output("b2b_no_bubble", 64'(waited), 64'd0);

        // Stall mid-frame while six grants arrive: four queue, two drop, bus frozen.
        apply_stimulus(16'd2, 8'h80, 16'd184, sel);
        waited = 0;
        while (tx_valid !== 1'b1 && waited < 10) begin
            step();
            waited++;
        end
        step();
        step();
        step();
        tx_ready = 1'b0;
        #1;
        snap = {tx_data, tx_keep, tx_sop, tx_eop, tx_valid, tx_stream_id};
        check_output("stall_valid", {63'd0, tx_valid}, 64'd1);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            if (c < 6) apply_stimulus(16'(10 + c), 8'h80, 16'd84, sel);
            else step();
            if ({tx_data, tx_keep, tx_sop, tx_eop, tx_valid, tx_stream_id} !== snap) bad++;
        end
        check_output("stall_frozen", 64'(bad), 64'd0);
        check_output("stall_drop_count", 64'(drop_count), 64'd2);
        tx_ready = 1'b1;
        sops = 0;
        eops = 0;
        for (int c = 0; c < 300; c++) begin
            if (tx_valid && tx_sop) sops++;
            if (tx_valid && tx_eop) eops++;
            step();
        end
        check_output("drain_sops", 64'(sops), 64'd4);
        check_output("drain_eops", 64'(eops), 64'd5);
        seq_model[2]++;
        for (int i = 10; i < 14; i++) seq_model[i]++;

        // Out-of-range IDs and non-grant codes produce nothing and are not counted.
        bad = 0;
        apply_stimulus(16'd0, 8'h80, 16'd84, sel);
        if (tx_valid) bad++;
        apply_stimulus(16'd65, 8'h80, 16'd84, sel);
        if (tx_valid) bad++;
        apply_stimulus(16'd3, 8'h81, 16'd84, sel);
        if (tx_valid) bad++;
        for (int c = 0; c < 6; c++) begin
            step();
            if (tx_valid) bad++;
        end
        check_output("ignored_no_frame", 64'(bad), 64'd0);
        check_output("ignored_no_drop", 64'(drop_count), 64'd2);

        // Disabling tx_enable lets a queued frame finish but blocks new grants.
        apply_stimulus(16'd20, 8'h80, 16'd184, sel);
        apply_stimulus(16'd6, 8'h80, 16'd84, sel);
        tx_enable   = 1'b0;
        sched_id    = 16'd7;
        sched_valid = 8'h80;
        len_in      = 16'd84;
        collect_frame("en_first", 16'd20, 164, exp_seq(20), waited, lk, lb);
        seq_model[20]++;
        collect_frame("en_queued", 16'd6, 64, exp_seq(6), waited, lk, lb);
        seq_model[6]++;
        check_output("en_queued_no_bubble", 64'(waited), 64'd0);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            if (tx_valid) bad++;
            step();
        end
        sched_valid = 8'd0;
        sched_id    = 16'd0;
        len_in      = 16'd0;
        check_output("disabled_no_frame", 64'(bad), 64'd0);
        tx_enable = 1'b1;

        // Asynchronous reset in the middle of a maximum-length frame.
        apply_stimulus(16'd7, 8'h80, 16'd20000, sel);
        waited = 0;
        while (tx_valid !== 1'b1 && waited < 10) begin
            step();
            waited++;
        end
        check_output("max_header_len", 64'(tx_data[63:48]), 64'h0024);
        for (int c = 0; c < 100; c++) step();
        lanes_checked = 0;
        for (int j = 0; j < 8; j++) if (tx_data[8*j +: 8] == 8'(800 + j)) lanes_checked++;
        check_output("beat100_pattern", 64'(lanes_checked), 64'd8);
        #2;
        reset_n = 1'b0;
        #1;
        check_output("midreset_data", tx_data, 64'd0);
        check_output("midreset_ctrl", {21'd0, tx_valid, tx_sop, tx_eop, tx_keep, tx_stream_id, drop_count}, 64'd0);
        #2;
        reset_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (tx_valid) bad++;
        end
        check_output("post_reset_idle", 64'(bad), 64'd0);

        // Sequence counters restart from zero after reset.
        for (int i = 0; i <= 64; i++) seq_model[i] = 32'd0;
        apply_stimulus(16'd3, 8'h80, 16'd84, sel);
        collect_frame("post_reset_frame", 16'd3, 64, exp_seq(3), waited, lk, lb);
        check_output("post_reset_latency", 64'(waited), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
        $finish;
    end

endmodule

// File: doc/stream_frame_builder_10g.md
# stream_frame_builder_10g

Downstream stage of the 10G bandwidth scheduler. Consumes its per-cycle frame-start grants (`current_id`, `valid`), looks up the stream's wire length, and emits one synthetic Ethernet frame per grant as a 64-bit, 8-lane beat stream carrying stream ID, per-stream sequence number and a byte-offset fill pattern. A small request FIFO absorbs grants that arrive while a frame is in flight or while the MAC side stalls.

## Interface
- `NUM_STREAMS`, 64: valid stream IDs are 1..NUM_STREAMS.
- `FIFO_DEPTH`, 4: request FIFO entries, power of two.
- `MAX_LEN`, 9216: maximum emitted frame bytes.
- `clock`  in  1  single clock, 156.25 MHz.
- `reset_n`  in  1  asynchronous, active-low reset.
- `tx_enable`  in  1  grants are accepted only while high.
- `sched_id`  in  16  scheduler `current_id`.
- `sched_valid`  in  8  scheduler `valid`; 8'h80 marks a grant.
- `len_sel`  out  6  combinational, `sched_id - 1`; selects the frame_lenNN entry.
- `len_in`  in  16  wire length (preamble + IFG included) for `len_sel`, same cycle.
- `tx_data`  out  64  frame bytes, lane 0 = `[7:0]` = first byte.
- `tx_keep`  out  8  byte-lane enables.
- `tx_sop` / `tx_eop`  out  1  first / last beat of frame.
- `tx_valid`  out  1  beat valid.
- `tx_ready`  in  1  sink accepts beat when `tx_valid && tx_ready`.
- `tx_stream_id`  out  16  ID of the frame on the bus.
- `drop_count`  out  16  saturating count of dropped grants.

## Operation
- Grant: `tx_enable && sched_valid==8'h80 && 1<=sched_id<=NUM_STREAMS`. Other IDs, including 0, are ignored and not counted.
- Frame bytes: L = `len_in` - 20, clamped to [64, MAX_LEN]. {id, L} is pushed to the FIFO.
- FIFO full on a grant: the grant is dropped and `drop_count` increments, saturating at 16'hFFFF.
- FSM states:
  - IDLE: pop when the FIFO is non-empty, then go to SOP.
  - SOP: beat 0, then go to BODY, or to IDLE/SOP directly if L fits one beat (never the case given the 64-byte minimum).
  - BODY: advance on handshake. On the last beat, pop the next request if one is present (→ SOP), otherwise → IDLE.
- Beat 0 bytes 0-1 = stream ID, big-endian. Bytes 2-5 = sequence number, big-endian. Bytes 6-7 = L. Byte k for k≥8 = k[7:0].
- Beats = ceil(L/8). The last beat has `tx_keep` = 8'hFF if L%8==0, else the low L%8 bits set. All other beats are 8'hFF.
- The per-stream sequence counter (32-bit, wraps) increments when that stream's SOP beat handshakes.
- `tx_enable` low: new grants are ignored. Queued and in-flight frames complete normally.

## Timing
- Reset values: outputs 0, FSM IDLE, FIFO empty, all sequence counters 0, `drop_count` 0.
- Latency: grant in cycle N with FIFO empty and FSM idle gives an SOP beat with `tx_valid` at N+2.
- Back-to-back: an EOP handshake in cycle M with a non-empty FIFO gives the next SOP at M+1, with no bubble.
- `tx_ready` low: all `tx_*` outputs hold stable; grants continue to queue.
- Push and pop in the same cycle when full: the pop frees the slot and the push succeeds, with no drop.
- `reset_n` asserted mid-frame: outputs clear asynchronously. No partial EOP is generated.

## Configuration
- `FRAME_BUILDER_SEQ_EN` defined: the per-stream counter array is present and bytes 2-5 carry the sequence number.
- Undefined: no counter storage, bytes 2-5 are 0, and all other behaviour is identical.

## Structure
- Shared package `bw10g_pkg`:
  - grant code `GRANT_SOP = 8'h80`
  - overhead constant `WIRE_OVERHEAD = 20`
  - minimum frame `MIN_FRAME = 64`
  - request struct `{id[15:0], len[13:0]}`
  - FSM state enum
- One sub-module: `bw10g_req_fifo`, a synchronous FIFO with full/empty flags and simultaneous push/pop.

## Test plan
- Single grant, id 3, `len_in` 84: L = 64 gives 8 beats at N+2 to N+9. Beat 0 = 16'h0003, seq 0, 16'h0040. Last `tx_keep` = 8'hFF.
- `len_in` 85, id 1: L = 65 gives 9 beats. Last `tx_keep` = 8'h01 and last data byte = 8'h40.
- Two grants 1 cycle apart, id 5 then id 5, `tx_ready` = 1: the second SOP follows the first EOP immediately, with seq 0 then 1.
- `tx_ready` held low for 20 cycles while 6 grants arrive: 4 queued, 2 dropped, `drop_count` = 2, and the outputs stay frozen.
- Grants with id 0 and id 65: no FIFO entry and `drop_count` unchanged. Then `tx_enable` = 0 while a grant is queued: the queued frame still completes.
- `len_in` 10 gives L = 64, and `len_in` 20000 gives L = 9216 (1152 beats). `reset_n` pulsed at beat 100: all outputs are 0 immediately and `tx_valid` stays 0 afterwards.
